scoreboard_stall: RTL and testbench
===================================

# scoreboard_stall

Parametrised hazard-detection unit for the 5-stage pipeline that decides when the Decode stage must hold. It generalises the single-cycle load-use check to loads with multi-cycle memory latency and adds a one-entry scoreboard for the iterative multiply/divide unit. It also adds a saturating stall-cycle performance counter. It sits beside the D/X pipeline latch: its stall output freezes PC, F/D and D, and injects a bubble into X.

## Interface
- `REG_W`, default 5, register-index width
- `OP_W`, default 5, opcode and ALU-op width
- `LOAD_LAT`, default 1, cycles from a load in X until its data can be bypassed; must be ≥ 1
- `CNT_W`, default 32, width of the stall counter
- `clock` in 1, sole clock; all state updates on the rising edge
- `reset` in 1, synchronous, active-high
- `op_D` in OP_W, opcode of the instruction in D
- `aluop_D` in OP_W, ALU op field of the instruction in D
- `rs_D`, `rt_D`, `rd_D` in REG_W each, register fields of the instruction in D
- `op_X` in OP_W, opcode of the instruction in X
- `rd_X` in REG_W, destination register of the instruction in X
- `flush_X` in 1, the X instruction is squashed this cycle
- `md_start` in 1, mul/div accepted by the multdiv unit this cycle
- `md_rd` in REG_W, destination register of that mul/div
- `md_done` in 1, multdiv result written back this cycle (one-cycle pulse)
- `stall` out 1, hold D and bubble X
- `stall_load` out 1, cause: load-use hazard
- `stall_md` out 1, cause: multdiv hazard
- `stall_count` out CNT_W, saturating count of stalled cycles

## Operation
- Opcode constants:
  - R-type 00000, sw 00111, lw 01000, bne 00010, blt 00110, jr 00100
  - J-type (no source register): 00001, 00011, 10101, 10110
  - ALU ops: mul 00110, div 00111
- Sources read by the D instruction:
  - `rs_D` unless J-type.
  - `rt_D` only if R-type.
  - `rd_D` if sw, bne, blt or jr.
- Register 0 never matches. A source equal to 0 never causes a stall.
- Load tracker:
  - Entry 0 is combinational: valid = (`op_X`==lw) && !`flush_X`, reg = `rd_X`.
  - Entries 1..LOAD_LAT-1 are registered. They shift every cycle regardless of `stall`, because the bubble does not stop older stages.
  - Entry k+1 ← entry k.
- `stall_load` = any valid tracker entry whose reg equals a used, nonzero D source.
- Multdiv scoreboard state: `md_busy`, `md_reg`. Updates per cycle:
  - `md_done` clears `md_busy`.
  - `md_start` then sets `md_busy` and loads `md_reg` ← `md_rd`. Start wins over done in the same cycle.
  - `md_done` with `md_busy`=0 is ignored.
- `stall_md` = `md_busy` && any of:
  - D is R-type mul/div (structural hazard)
  - a used D source equals `md_reg`
  - D writes a register (R-type, or opcode 00101/lw) with `rd_D` == `md_reg` (WAW)
  - In all three cases `md_reg` must be nonzero.
- `stall` = `stall_load` | `stall_md`.
- Counter: `stall_count` increments when `stall`=1 and saturates at all-ones.

## Timing
- `stall`, `stall_load` and `stall_md` are combinational from current inputs and registered state, within the same cycle.
- While `reset`=1, all three are forced to 0.
- On reset:
  - tracker entries 1..LOAD_LAT-1 invalid
  - `md_busy`=0, `md_reg`=0
  - `stall_count`=0
- A reset mid-operation abandons the pending mul/div scoreboard entry. The multdiv unit is reset by the same signal.
- Load-use stall length: with LOAD_LAT=L, a consumer directly behind a lw stalls L cycles.
- Multdiv stall length: a dependent instruction stalls until the cycle after `md_done`, i.e. it proceeds in the cycle `md_busy` reads 0.
- A flushed lw in X creates no tracker entry, including in later cycles.

## Structure
- Package `hazard_pkg` holds:
  - the opcode and ALU-op constants
  - a function `reads_rd(op)` for the rd-as-source rule
  - a function `is_jtype(op)`
- Sub-module `load_track`:
  - parametrised by LOAD_LAT and REG_W
  - registered valid/reg shift chain plus comparator
  - outputs a one-bit match for two query registers

## Test plan
- LOAD_LAT=1: lw r5 in X, D = add r1,r5,r2 → `stall`=1 for exactly 1 cycle. Same with D = sw r5,0(r3) → `stall`=1 via rd. Same with D = addi r1,r3,4 (rt=5 unused) → `stall`=0.
- LOAD_LAT=3: lw r7 in X, consumer of r7 in D → `stall`=1 for 3 cycles, then 0. Assert `flush_X` on the lw → 0 stall cycles. lw r0 → never stalls.
- `md_start` with `md_rd`=9, `md_done` 32 cycles later:
  - D = add r2,r9,r1 stalls until the cycle after done, with `stall_md`=1.
  - D = add r9,r1,r1 (WAW) stalls.
  - D = add r2,r3,r4 does not stall.
- D = mul while `md_busy` → stall. `md_done` and `md_start`(rd=4) in the same cycle → `md_busy`=1, `md_reg`=4.
- Reset asserted while `md_busy` with a LOAD_LAT=3 chain full → next cycle `stall`=0, `stall_count`=0, no residual stalls.
- CNT_W=4: hold a hazard for 20 cycles → `stall_count` reaches 15 and holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - opcode constants and source-decode helpers for the hazard unit
package hazard_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Instructions whose rd field names a register that is read, not written.
  function automatic logic reads_rd(input logic [4:0] op);
    return (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);
  endfunction

  function automatic logic is_jtype(input logic [4:0] op);
    return (op == 5'b00001) || (op == 5'b00011) || (op == 5'b10101) || (op == 5'b10110);
  endfunction

endpackage

// File: rtl/scoreboard_stall_if.sv
// rtl/scoreboard_stall_if.sv - decode/execute view and stall outputs of the hazard unit
interface scoreboard_stall_if #(
  parameter int REG_W = 5,
  parameter int OP_W  = 5,
  parameter int CNT_W = 32
);
  logic [OP_W-1:0]  op_D;
  logic [OP_W-1:0]  aluop_D;
  logic [REG_W-1:0] rs_D;
  logic [REG_W-1:0] rt_D;
  logic [REG_W-1:0] rd_D;
  logic [OP_W-1:0]  op_X;
  logic [REG_W-1:0] rd_X;
  logic             flush_X;
  logic             md_start;
  logic [REG_W-1:0] md_rd;
  logic             md_done;
  logic             stall;
  logic             stall_load;
  logic             stall_md;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output op_D, aluop_D, rs_D, rt_D, rd_D, op_X, rd_X, flush_X, md_start, md_rd, md_done,
    input  stall, stall_load, stall_md, stall_count
  );

  modport slave (
    input  op_D, aluop_D, rs_D, rt_D, rd_D, op_X, rd_X, flush_X, md_start, md_rd, md_done,
    output stall, stall_load, stall_md, stall_count
  );
endinterface

// File: rtl/load_track.sv
// rtl/load_track.sv - in-flight load shift chain; flags a match against two D-stage sources
module load_track #(
  parameter int LOAD_LAT = 1,
  parameter int REG_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [REG_W-1:0] in_reg,
  input  logic             qa_en,
  input  logic [REG_W-1:0] qa_reg,
  input  logic             qb_en,
  input  logic [REG_W-1:0] qb_reg,
  output logic             match
);

  // Entry 0 is the live X-stage load; only entries 1..LOAD_LAT-1 are stored.
  localparam int DEPTH = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [REG_W-1:0] reg_q [DEPTH];
  logic [REG_W-1:0] reg_d [DEPTH];

  function automatic logic hits(input logic v, input logic [REG_W-1:0] r,
                                input logic a_en, input logic [REG_W-1:0] a,
                                input logic b_en, input logic [REG_W-1:0] b);
    return v && (r != '0) && ((a_en && (a == r)) || (b_en && (b == r)));
  endfunction

  always_comb begin
    vld_d    = '0;
    reg_d    = '{default: '0};
    vld_d[0] = in_valid;
    reg_d[0] = in_reg;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      reg_d[k] = reg_q[k-1];
    end
    match = hits(in_valid, in_reg, qa_en, qa_reg, qb_en, qb_reg);
    for (int k = 0; k < DEPTH; k++) begin
      if (k < LOAD_LAT - 1) begin
        match = match | hits(vld_q[k], reg_q[k], qa_en, qa_reg, qb_en, qb_reg);
      end
    end
  end

  // Shifts unconditionally: a D-stage stall never holds older stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      reg_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      reg_q <= reg_d;
    end
  end

endmodule

// File: rtl/scoreboard_stall.sv
// rtl/scoreboard_stall.sv - decode hold logic for multi-cycle loads and the iterative mul/div unit
module scoreboard_stall
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int OP_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic               clock,
  input logic               reset,
  scoreboard_stall_if.slave bus
);

  logic [OP_W-1:0]  op_dec, alu_dec, op_ex;
  logic [REG_W-1:0] rs_dec, rt_dec, rd_dec, rd_ex;
  logic             use_rs, use_rt, use_rd, q2_en;
  logic [REG_W-1:0] q2_reg;
  logic             load_hit, md_hit;
  logic             md_busy_q, md_busy_d;
  logic [REG_W-1:0] md_reg_q, md_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_w;

  assign op_dec  = bus.op_D;
  assign alu_dec = bus.aluop_D;
  assign op_ex   = bus.op_X;
  assign rs_dec  = bus.rs_D;
  assign rt_dec  = bus.rt_D;
  assign rd_dec  = bus.rd_D;
  assign rd_ex   = bus.rd_X;

  assign use_rs = !is_jtype(op_dec);
  assign use_rt = (op_dec == OP_RTYPE);
  assign use_rd = reads_rd(op_dec);

  // rt and rd-as-source never apply to the same opcode, so one port covers both.
  assign q2_en  = use_rt | use_rd;
  assign q2_reg = use_rt ? rt_dec : rd_dec;

  load_track #(
    .LOAD_LAT (LOAD_LAT),
    .REG_W    (REG_W)
  ) u_load_track (
    .clock    (clock),
    .reset    (reset),
    .in_valid ((op_ex == OP_LW) && !bus.flush_X),
    .in_reg   (rd_ex),
    .qa_en    (use_rs),
    .qa_reg   (rs_dec),
    .qb_en    (q2_en),
    .qb_reg   (q2_reg),
    .match    (load_hit)
  );

  always_comb begin
    md_busy_d = md_busy_q;
    md_reg_d  = md_reg_q;
    if (bus.md_done) md_busy_d = 1'b0;
    if (bus.md_start) begin
      md_busy_d = 1'b1;
      md_reg_d  = bus.md_rd;
    end
  end

  always_comb begin
    md_hit = 1'b0;
    if (md_busy_q && (md_reg_q != '0)) begin
      md_hit = (use_rt && ((alu_dec == ALU_MUL) || (alu_dec == ALU_DIV)))
             | (use_rs && (rs_dec == md_reg_q))
             | (q2_en  && (q2_reg == md_reg_q))
             | (((op_dec == OP_RTYPE) || (op_dec == OP_ADDI) || (op_dec == OP_LW))
                && (rd_dec == md_reg_q));
    end
  end

  assign bus.stall_load = !reset && load_hit;
  assign bus.stall_md   = !reset && md_hit;
  assign stall_w        = bus.stall_load | bus.stall_md;
  assign bus.stall      = stall_w;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_w && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      md_busy_q <= 1'b0;
      md_reg_q  <= '0;
      cnt_q     <= '0;
    end else begin
      md_busy_q <= md_busy_d;
      md_reg_q  <= md_reg_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_scoreboard_stall.sv
// tb/tb_scoreboard_stall.sv - directed bench driving a LOAD_LAT=1 and a LOAD_LAT=3/CNT_W=4 instance in lockstep
module tb_scoreboard_stall;
  import hazard_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] op_D, aluop_D, rs_D, rt_D, rd_D, op_X, rd_X, md_rd;
  logic       flush_X, md_start, md_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  scoreboard_stall_if #(.REG_W(5), .OP_W(5), .CNT_W(32)) if_a ();
  scoreboard_stall_if #(.REG_W(5), .OP_W(5), .CNT_W(4))  if_b ();

  assign if_a.op_D = op_D;   assign if_b.op_D = op_D;
  assign if_a.aluop_D = aluop_D; assign if_b.aluop_D = aluop_D;
  assign if_a.rs_D = rs_D;   assign if_b.rs_D = rs_D;
  assign if_a.rt_D = rt_D;   assign if_b.rt_D = rt_D;
  assign if_a.rd_D = rd_D;   assign if_b.rd_D = rd_D;
  assign if_a.op_X = op_X;   assign if_b.op_X = op_X;
  assign if_a.rd_X = rd_X;   assign if_b.rd_X = rd_X;
  assign if_a.flush_X = flush_X;   assign if_b.flush_X = flush_X;
  assign if_a.md_start = md_start; assign if_b.md_start = md_start;
  assign if_a.md_rd = md_rd;       assign if_b.md_rd = md_rd;
  assign if_a.md_done = md_done;   assign if_b.md_done = md_done;

  scoreboard_stall #(.REG_W(5), .OP_W(5), .LOAD_LAT(1), .CNT_W(32)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.slave)
  );

  scoreboard_stall #(.REG_W(5), .OP_W(5), .LOAD_LAT(3), .CNT_W(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.slave)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    op_D = OP_RTYPE; aluop_D = '0; rs_D = '0; rt_D = '0; rd_D = '0;
    op_X = OP_RTYPE; rd_X = '0; flush_X = 1'b0;
    md_start = 1'b0; md_rd = '0; md_done = 1'b0;
  endtask

  task automatic set_d(input logic [4:0] op, input logic [4:0] alu,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    op_D = op; aluop_D = alu; rs_D = rs; rt_D = rt; rd_D = rd;
  endtask

  // lw in X for one cycle, then bubbles; D held constant; counts load-stall cycles.
  task automatic run_load(input string tag, input logic [4:0] xrd, input logic xflush,
                          input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input int exp_a, input int exp_b);
    int na = 0;
    int nb = 0;
    for (int c = 0; c < 5; c++) begin
      op_X    = (c == 0) ? OP_LW : OP_RTYPE;
      rd_X    = (c == 0) ? xrd : 5'd0;
      flush_X = (c == 0) ? xflush : 1'b0;
      set_d(op, 5'd0, rs, rt, rd);
      #1;
      na += int'(if_a.stall_load);
      nb += int'(if_b.stall_load);
      tick();
    end
    check({tag, "_lat1"}, na, exp_a);
    check({tag, "_lat3"}, nb, exp_b);
    idle();
  endtask

  // mul/div to r9 accepted, done 32 cycles later; D held over 34 cycles after start.
  task automatic run_md(input string tag, input logic [4:0] op, input logic [4:0] alu,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input int exp_cycles);
    int na = 0;
    int nb = 0;
    idle();
    md_start = 1'b1; md_rd = 5'd9;
    tick();
    md_start = 1'b0; md_rd = '0;
    for (int c = 1; c <= 34; c++) begin
      md_done = (c == 32);
      set_d(op, alu, rs, rt, rd);
      #1;
      na += int'(if_a.stall_md);
      nb += int'(if_b.stall_md);
      if (c == 33) check({tag, "_after_done"}, int'(if_a.stall), 0);
      tick();
    end
    check({tag, "_md_a"}, na, exp_cycles);
    check({tag, "_md_b"}, nb, exp_cycles);
    idle();
  endtask

  initial begin
    int nr;
    reset = 1'b1;
    idle();
    tick();
    tick();

    // Hazard present while reset is high: outputs must be held low.
    op_X = OP_LW; rd_X = 5'd5;
    set_d(OP_RTYPE, 5'd0, 5'd5, 5'd2, 5'd1);
    #1;
    check("rst_stall_a", int'(if_a.stall), 0);
    check("rst_stall_b", int'(if_b.stall), 0);
    check("rst_cnt_a", int'(if_a.stall_count), 0);
    check("rst_cnt_b", int'(if_b.stall_count), 0);
    idle();
    tick();
    reset = 1'b0;
    tick();

    run_load("add_r5",   5'd5, 1'b0, OP_RTYPE, 5'd5, 5'd2, 5'd1, 1, 3);
    run_load("sw_r5",    5'd5, 1'b0, OP_SW,    5'd3, 5'd0, 5'd5, 1, 3);
    run_load("addi_rt5", 5'd5, 1'b0, OP_ADDI,  5'd3, 5'd5, 5'd1, 0, 0);
    run_load("add_r7",   5'd7, 1'b0, OP_RTYPE, 5'd7, 5'd7, 5'd2, 1, 3);
    run_load("flush_r7", 5'd7, 1'b1, OP_RTYPE, 5'd7, 5'd7, 5'd2, 0, 0);
    run_load("lw_r0",    5'd0, 1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd2, 0, 0);
    run_load("jtype",    5'd5, 1'b0, 5'b00001, 5'd5, 5'd5, 5'd0, 0, 0);
    #1;
    check("cnt_a_loads", int'(if_a.stall_count), 3);
    check("cnt_b_loads", int'(if_b.stall_count), 9);

    run_md("raw_r9", OP_RTYPE, 5'd0,    5'd9, 5'd1, 5'd2, 32);
    run_md("waw_r9", OP_RTYPE, 5'd0,    5'd1, 5'd1, 5'd9, 32);
    run_md("indep",  OP_RTYPE, 5'd0,    5'd3, 5'd4, 5'd2, 0);
    run_md("mul",    OP_RTYPE, ALU_MUL, 5'd3, 5'd4, 5'd2, 32);
    #1;
    check("cnt_a_md", int'(if_a.stall_count), 99);
    check("cnt_b_sat", int'(if_b.stall_count), 15);

    // Start wins over done in the same cycle.
    md_start = 1'b1; md_rd = 5'd9;
    tick();
    md_start = 1'b0;
    tick();
    md_done = 1'b1; md_start = 1'b1; md_rd = 5'd4;
    tick();
    md_done = 1'b0; md_start = 1'b0; md_rd = '0;
    set_d(OP_RTYPE, 5'd0, 5'd4, 5'd1, 5'd2);
    #1;
    check("sim_rd4", int'(if_a.stall_md), 1);
    set_d(OP_RTYPE, 5'd0, 5'd9, 5'd1, 5'd2);
    #1;
    check("sim_rd9", int'(if_b.stall_md), 0);
    set_d(OP_RTYPE, ALU_DIV, 5'd0, 5'd0, 5'd0);
    #1;
    check("sim_div", int'(if_b.stall_md), 1);
    idle();
    md_done = 1'b1;
    tick();
    idle();
    tick();

    // Fill the LOAD_LAT=3 chain with r7 and leave r9 pending, then reset.
    md_start = 1'b1; md_rd = 5'd9;
    op_X = OP_LW; rd_X = 5'd7;
    tick();
    md_start = 1'b0; md_rd = '0;
    tick();
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nr = 0;
    for (int c = 0; c < 3; c++) begin
      set_d(OP_RTYPE, 5'd0, 5'd7, 5'd9, 5'd2);
      #1;
      if (c == 0) begin
        check("post_rst_cnt_a", int'(if_a.stall_count), 0);
        check("post_rst_cnt_b", int'(if_b.stall_count), 0);
      end
      nr += int'(if_a.stall) + int'(if_b.stall);
      tick();
    end
    check("post_rst_stalls", nr, 0);
    idle();

    // Long-held hazard: narrow counter saturates, wide one keeps counting.
    md_start = 1'b1; md_rd = 5'd9;
    tick();
    md_start = 1'b0; md_rd = '0;
    for (int c = 0; c < 20; c++) begin
      set_d(OP_RTYPE, 5'd0, 5'd9, 5'd1, 5'd2);
      #1;
      if (c == 14) check("cnt_b_14", int'(if_b.stall_count), 14);
      tick();
    end
    check("cnt_b_hold", int'(if_b.stall_count), 15);
    check("cnt_a_20", int'(if_a.stall_count), 20);
    idle();
    md_done = 1'b1;
    tick();
    idle();
    set_d(OP_RTYPE, 5'd0, 5'd9, 5'd1, 5'd2);
    #1;
    check("done_clears", int'(if_a.stall), 0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
